upsample2x_nn: RTL
==================

// Module: upsample2x_nn
// PURPOSE
// - Streaming 2x nearest-neighbour upsampler for the YOLOv3-Tiny route branch (13x13 -> 26x26).
// - Inverse direction of the 2x2/s2 maxpool layers; each input pixel becomes a 2x2 output block.
// - Raster-order pixel stream; one DATA_WIDTH word = 16 channel lanes x 32-bit float, copied bit-exact.
// - Ready/valid on both sides; 4 output beats per input pixel, so input is throttled to 1/4 rate.
// PARAMETERS
// - DATA_WIDTH  512  pixel word width (16 lanes x 32 bit), no arithmetic on contents
// - IMG_SIZE    13   input width = height; output is 2*IMG_SIZE square
// - ADDR_WIDTH  localparam $clog2(IMG_SIZE); row-buffer address / column counter width
// PORTS
// - Clk        in   1           clock, all logic on rising edge
// - Rst        in   1           asynchronous, active-high reset
// - data_in    in   DATA_WIDTH  input pixel, raster order
// - valid_in   in   1           data_in valid
// - ready_in   out  1           block accepts data_in this cycle (transfer = valid_in & ready_in)
// - data_out   out  DATA_WIDTH  upsampled pixel, registered
// - valid_out  out  1           data_out valid, registered
// - ready_out  in   1           downstream accepts (transfer = valid_out & ready_out)
// - last_out   out  1           only with UPSAMPLE2X_LAST_EN; see CONFIGURATION
// BEHAVIOUR
// - Reset (async): state=PASS1, col=0, row=0, rep=0, data_out=0, valid_out=0, ready_in=0 during Rst,
//   last_out=0. Row buffer contents not cleared. Reset mid-frame discards partial row/frame.
// - FSM per input row: PASS1 (accept row, emit each pixel twice, write pixel to row_buf[col])
//   -> PASS2 (replay row_buf[0..IMG_SIZE-1], each word twice, no input) -> PASS1 next row.
// - rep bit: 0 = first copy on data_out, 1 = second copy. Output reg loads new word only when
//   !valid_out, or (valid_out & ready_out & rep==1). Load sets rep=0; handshake with rep==0 sets rep=1.
// - ready_in = (state==PASS1) & load-condition; combinational from registered state and ready_out.
// - Input-to-output latency: 1 cycle (data_out/valid_out updated on the edge that accepts data_in).
// - Stall: while valid_out & !ready_out, data_out, rep, counters held stable; no beat dropped/duplicated.
// - PASS2 reads row_buf with 1-cycle synchronous read; read for col is issued ahead so valid_out drops
//   for at most 1 cycle at PASS1->PASS2 and PASS2->PASS1 boundaries; none inside a pass.
// - col wraps IMG_SIZE-1 -> 0 on last load of a pass; PASS1 wrap -> PASS2; PASS2 wrap -> PASS1, row++.
// - row wraps IMG_SIZE-1 -> 0 after PASS2 of last row (frame end); next frame starts without gap/reset.
// - Output per frame: exactly 4*IMG_SIZE^2 beats; row r of input yields output rows 2r and 2r+1.
// - Simultaneous last input beat and output stall: the input beat is not accepted (ready_in=0) until
//   the load-condition holds; row_buf write and output load happen on the same edge.
// - valid_in high in PASS2 is ignored (ready_in=0); data_in need not be stable when not accepted.
// CONFIGURATION
// - UPSAMPLE2X_LAST_EN defined: port last_out present; last_out=1 with the final beat of a frame
//   (PASS2, row=IMG_SIZE-1, col=IMG_SIZE-1, rep=1), qualified by valid_out; held stable under stall.
// - Not defined: no last_out port, no frame-end decode; all other behaviour identical.
// STRUCTURE
// - Shared package yolo_pkg: LANE_WIDTH=32, NUM_LANES=16, DATA_WIDTH default, pass-state enum
//   (PASS1, PASS2) typedef.
// - Sub-module upsample_row_buf: simple dual-port RAM, IMG_SIZE x DATA_WIDTH, 1 write port,
//   1 sync-read port, no reset; infers block RAM.
// - Top holds FSM, col/row/rep counters, output register, ready_in decode.
// TESTING
// - IMG_SIZE=2, inputs A,B,C,D, ready_out=1 -> out A,A,B,B,A,A,B,B,C,C,D,D,C,C,D,D; 16 beats.
// - IMG_SIZE=4, ready_out pattern 1,0,1,0... -> same sequence as ready_out=1; data_out stable on stalls.
// - IMG_SIZE=4, valid_in held high all frame -> ready_in=0 throughout every PASS2 and on rep=0 beats;
//   all 16 inputs consumed exactly once, 64 output beats.
// - Rst asserted mid PASS2 of row 1 -> valid_out=0 immediately; next frame restarts at row 0 col 0
//   with correct 2x2 replication, stale row_buf never emitted before rewrite.
// - Two back-to-back IMG_SIZE=13 frames, lanes filled with distinct float patterns -> 676 beats each,
//   bit-exact per lane vs golden model; with UPSAMPLE2X_LAST_EN last_out pulses on beats 676 and 1352.
// - Random valid_in/ready_out (50%) over 3 frames -> scoreboard matches nearest-neighbour model.

Source files
------------

// File: rtl/yolo_pkg.sv
// Shared constants and types for the YOLOv3-Tiny streaming pixel blocks.
package yolo_pkg;

    localparam int unsigned LANE_WIDTH = 32;
    localparam int unsigned NUM_LANES  = 16;
    localparam int unsigned DATA_WIDTH = LANE_WIDTH * NUM_LANES;

    // Row phase of the upsampler: Pass1 consumes an input row, Pass2 replays it from the buffer.
    typedef enum logic {
        Pass1 = 1'b0,
        Pass2 = 1'b1
    } pass_state_e;

endpackage

// File: rtl/upsample2x_nn_if.sv
// Pixel stream bundle for upsample2x_nn: input side (data_in/valid_in/ready_in) and output side
// (data_out/valid_out/ready_out). last_out exists only when UPSAMPLE2X_LAST_EN is defined.
interface upsample2x_nn_if #(
    parameter int unsigned DATA_WIDTH = yolo_pkg::DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic                  ready_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_out;

`ifdef UPSAMPLE2X_LAST_EN
    logic                  last_out;

    modport master (
        output data_in, valid_in, ready_out,
        input  ready_in, data_out, valid_out, last_out
    );
    modport slave (
        input  data_in, valid_in, ready_out,
        output ready_in, data_out, valid_out, last_out
    );
`else
    modport master (
        output data_in, valid_in, ready_out,
        input  ready_in, data_out, valid_out
    );
    modport slave (
        input  data_in, valid_in, ready_out,
        output ready_in, data_out, valid_out
    );
`endif

endinterface

// File: rtl/upsample_row_buf.sv
// One-row pixel buffer: simple dual-port RAM, one write port, one synchronous read port.
// No reset so it maps onto block RAM.
module upsample_row_buf #(
    parameter int unsigned Depth     = 13,
    parameter int unsigned Width     = 512,
    parameter int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [Width-1:0]     wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [Width-1:0]     rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    // Write port and registered read port (read returns the old word on a same-address write).
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/upsample2x_nn.sv
// Streaming 2x nearest-neighbour upsampler: each input pixel becomes a 2x2 output block.
// Pass1 emits every pixel of a row twice while storing it; Pass2 replays the stored row twice
// per pixel. Define UPSAMPLE2X_LAST_EN to add the frame-end flag last_out.
module upsample2x_nn
    import yolo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = yolo_pkg::DATA_WIDTH,
    parameter int unsigned IMG_SIZE   = 13
) (
    input  logic           Clk,
    input  logic           Rst,
    upsample2x_nn_if.slave bus
);

    localparam int unsigned ADDR_WIDTH = $clog2(IMG_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(IMG_SIZE - 1);

    pass_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] col_q, col_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic                  rep_q, rep_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  load;
    logic                  handshake;
    logic                  accept;
    logic                  advance;

    // Output register may take a new word when empty or when its second copy leaves.
    assign load      = !valid_q || (bus.ready_out && rep_q);
    assign handshake = valid_q && bus.ready_out;
    assign accept    = bus.valid_in && bus.ready_in;

    assign bus.ready_in  = !Rst && (state_q == Pass1) && load;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;

    // The read address always tracks col; Pass2 loads are two handshakes apart, so the word
    // for the current col is ready by the time it is needed.
    upsample_row_buf #(
        .Depth     (IMG_SIZE),
        .Width     (DATA_WIDTH),
        .AddrWidth (ADDR_WIDTH)
    ) u_row_buf (
        .clk_i   (Clk),
        .we_i    (accept),
        .waddr_i (col_q),
        .wdata_i (bus.data_in),
        .raddr_i (col_q),
        .rdata_o (rd_data)
    );

`ifdef UPSAMPLE2X_LAST_EN
    logic last_q, last_d;

    // Flag is latched with the final word of the frame and shown on its second copy only.
    always_comb begin
        last_d = last_q;
        if (load) begin
            last_d = (state_q == Pass2) && (row_q == LAST_IDX) && (col_q == LAST_IDX);
        end
    end

    // Frame-end flag register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    assign bus.last_out = valid_q && rep_q && last_q;
`endif

    // Next-state: output register load, copy counter and col/row/pass sequencing.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        rep_d   = rep_q;
        data_d  = data_q;
        valid_d = valid_q;
        advance = 1'b0;

        if (load) begin
            if (state_q == Pass2) begin
                data_d  = rd_data;
                valid_d = 1'b1;
                rep_d   = 1'b0;
                advance = 1'b1;
            end else if (accept) begin
                data_d  = bus.data_in;
                valid_d = 1'b1;
                rep_d   = 1'b0;
                advance = 1'b1;
            end else begin
                valid_d = 1'b0;
                rep_d   = 1'b0;
            end
        end else if (handshake) begin
            rep_d = 1'b1;
        end

        if (advance) begin
            if (col_q == LAST_IDX) begin
                col_d = '0;
                if (state_q == Pass1) begin
                    state_d = Pass2;
                end else begin
                    state_d = Pass1;
                    row_d   = (row_q == LAST_IDX) ? '0 : row_q + ADDR_WIDTH'(1);
                end
            end else begin
                col_d = col_q + ADDR_WIDTH'(1);
            end
        end
    end

    // State, counters and output register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= Pass1;
            col_q   <= '0;
            row_q   <= '0;
            rep_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            rep_q   <= rep_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule
